alu_bank: RTL

Parametrised multi-accumulator ALU on the shared tri-state data bus; successor to the single-accumulator bus ALU. It holds NACC accumulators selected per access and performs single-cycle add/sub/logic ops. Shifts and (optionally) multiply run as multi-cycle iterative ops with a `busy` handshake. It is controlled by the CPU sequencer with the same `wr`/`rd`/`op` strobes as the existing bus devices.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter.sv | 123 ++++++++++++
 rtl/alu_bank.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, iterative-engine FSM states and field widths shared by alu_bank.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SRL  = 4'b0010,
    OP_SRA  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_ADD  = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_MUL  = 4'b1100
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative engine, shifts one bit per cycle and (with ALU_BANK_MUL_EN)
// shift-add multiplies; done_o pulses in the cycle result_o holds the final value.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_shift_i,
  input  logic             start_mul_i,
  input  logic [1:0]       shift_kind_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output state_e           state_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [1:0]       kind_q, kind_d;

`ifdef ALU_BANK_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] addend;
  assign addend = mplier_q[0] ? mcand_q : '0;
`else
  logic unused_iter;
  assign unused_iter = start_mul_i ^ (^b_i[WIDTH-1:CW]);
`endif

  assign state_o = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_d    = tmp_q;
    kind_d   = kind_q;
    done_o   = 1'b0;
    result_o = tmp_q;
`ifdef ALU_BANK_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_shift_i) begin
          tmp_d   = a_i;
          cnt_d   = b_i[CW-1:0];
          kind_d  = shift_kind_i;
          state_d = SHIFT;
        end
`ifdef ALU_BANK_MUL_EN
        else if (start_mul_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          tmp_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = MUL;
        end
`endif
      end
      SHIFT: begin
        // The count reaching zero costs one extra cycle, so shamt 0 still shows busy once.
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (kind_q)
            2'b01:   tmp_d = tmp_q << 1;
            2'b10:   tmp_d = tmp_q >> 1;
            default: tmp_d = {tmp_q[WIDTH-1], tmp_q[WIDTH-1:1]};
          endcase
        end
      end
      MUL: begin
`ifdef ALU_BANK_MUL_EN
        tmp_d    = tmp_q + addend;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        result_o = tmp_q + addend;
        if (cnt_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmp_q    <= '0;
      kind_q   <= '0;
`ifdef ALU_BANK_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_q    <= tmp_d;
      kind_q   <= kind_d;
`ifdef ALU_BANK_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: rtl/alu_bank.sv
// alu_bank: NACC accumulators on a shared tri-state bus with single-cycle ALU ops and an
// iterative shift/multiply engine. Define ALU_BANK_MUL_EN to include the multiplier.
module alu_bank
  import alu_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  NACC  = 4,
  localparam int SELW  = $clog2(NACC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [OP_W-1:0]  op,
  input  logic [SELW-1:0]  sel,
  inout  wire  [WIDTH-1:0] bus,
  output logic             busy,
  output logic             zero,
  output logic             carry
);

  // Handshake: wr is taken only on an edge where busy is low and sel is in range;
  // rd drives the bus combinationally at any time, including while busy.

  logic [WIDTH-1:0] acc_q [NACC];
  logic [SELW-1:0]  sel_q, sel_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  logic             sel_ok;
  logic [WIDTH-1:0] acc_rd, opnd_b;
  state_e           iter_state;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic             accept, is_shift, is_mul;
  logic             start_shift, start_mul, single;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH:0]   sum;
  logic             wb_en;
  logic [SELW-1:0]  wb_idx;
  logic [WIDTH-1:0] wb_val;

  assign sel_ok = (32'(sel) < 32'(NACC));
  assign acc_rd = sel_ok ? acc_q[sel] : '0;
  assign bus    = rd ? acc_rd : 'z;
  // With rd and wr together the operand is our own drive, so ADD doubles and SUB clears.
  assign opnd_b = bus;

  assign busy     = (iter_state != IDLE);
  assign accept   = wr && !busy && sel_ok;
  assign is_shift = is_shift_op(op);
`ifdef ALU_BANK_MUL_EN
  assign is_mul   = (op == OP_MUL);
`else
  assign is_mul   = 1'b0;
`endif
  assign start_shift = accept && is_shift;
  assign start_mul   = accept && is_mul;
  assign single      = accept && !is_shift && !is_mul;

  always_comb begin
    alu_res   = opnd_b;
    alu_carry = carry_q;
    sum       = '0;
    case (op)
      OP_ADD: begin
        sum       = {1'b0, acc_rd} + {1'b0, opnd_b};
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        sum       = {1'b0, acc_rd} + {1'b0, ~opnd_b} + 1'b1;
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_AND:  alu_res = acc_rd & opnd_b;
      OP_OR:   alu_res = acc_rd | opnd_b;
      OP_XOR:  alu_res = acc_rd ^ opnd_b;
      default: alu_res = opnd_b;
    endcase
  end

  always_comb begin
    wb_en   = single || iter_done;
    wb_idx  = iter_done ? sel_q : sel;
    wb_val  = iter_done ? iter_res : alu_res;
    sel_d   = (start_shift || start_mul) ? sel : sel_q;
    zero_d  = wb_en ? (wb_val == '0) : zero_q;
    carry_d = single ? alu_carry : carry_q;
  end

  alu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_shift_i(start_shift),
    .start_mul_i  (start_mul),
    .shift_kind_i (op[1:0]),
    .a_i          (acc_rd),
    .b_i          (opnd_b),
    .state_o      (iter_state),
    .done_o       (iter_done),
    .result_o     (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      sel_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < NACC; i++) begin
        if (wb_en && (32'(wb_idx) == i)) acc_q[i] <= wb_val;
      end
      sel_q   <= sel_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;

endmodule
